serial_mag_comparator: RTL and testbench

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

---
 rtl/serial_cmp_pkg.sv | 19 +
 rtl/bit_cmp_cell.sv | 14 +
 rtl/serial_mag_comparator.sv | 147 ++++++++++++++
 tb/tb_serial_mag_comparator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types and sizing helpers for the bit-serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width: ceil(log2(value)), never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bit_cmp_cell.sv
// Combinational 1-bit magnitude compare; exactly one output is high.
module bit_cmp_cell (
  input  logic a_bit,
  input  logic b_bit,
  output logic eq,
  output logic lt,
  output logic gt
);

  assign eq = ~(a_bit ^ b_bit);
  assign lt = ~a_bit & b_bit;
  assign gt = a_bit & ~b_bit;

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit per clock.
// Optional early exit at the first differing bit; all outputs are registered.
module serial_mag_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int CW = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             pend_gt_q, pend_gt_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  logic bit_eq, bit_lt, bit_gt;
  logic decided_now, pend_gt_now;

  bit_cmp_cell u_cell (
    .a_bit (sh_a_q[WIDTH-1]),
    .b_bit (sh_b_q[WIDTH-1]),
    .eq    (bit_eq),
    .lt    (bit_lt),
    .gt    (bit_gt)
  );

  // In full-scan mode the first difference wins; later bits cannot override it.
  assign decided_now = decided_q | ~bit_eq;
  assign pend_gt_now = decided_q ? pend_gt_q : bit_gt;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d   = state_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    pend_gt_d = pend_gt_q;
    done_d    = 1'b0;
    eq_d      = eq_q;
    lt_d      = lt_q;
    gt_d      = gt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sh_a_d    = a;
          sh_b_d    = b;
          cnt_d     = CW'(WIDTH - 1);
          decided_d = 1'b0;
          pend_gt_d = 1'b0;
          eq_d      = 1'b0;
          lt_d      = 1'b0;
          gt_d      = 1'b0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        sh_a_d = sh_a_q << 1;
        sh_b_d = sh_b_q << 1;
        cnt_d  = cnt_q - CW'(1);

        if (EARLY_EXIT) begin
          if (!bit_eq) begin
            gt_d    = bit_gt;
            lt_d    = bit_lt;
            eq_d    = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            eq_d    = 1'b1;
            lt_d    = 1'b0;
            gt_d    = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          decided_d = decided_now;
          pend_gt_d = pend_gt_now;
          if (cnt_q == '0) begin
            eq_d    = ~decided_now;
            gt_d    = decided_now & pend_gt_now;
            lt_d    = decided_now & ~pend_gt_now;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: shift registers are ordinary flops here, so they are reset like the rest.
      state_q   <= IDLE;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      pend_gt_q <= 1'b0;
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      pend_gt_q <= pend_gt_d;
      done_q    <= done_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      gt_q      <= gt_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign eq   = eq_q;
  assign lt   = lt_q;
  assign gt   = gt_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench: three comparators (8-bit early exit, 8-bit full scan, 1-bit).
module tb_serial_mag_comparator;

  typedef struct {
    int   id;
    int   e0;
    int   done_cyc;
    int   lat;
    logic eq;
    logic lt;
    logic gt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_v, busy_v, done_v, eq_v, lt_v, gt_v;
  logic [7:0] a_v [3];
  logic [7:0] b_v [3];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .eq(eq_v[0]), .lt(lt_v[0]), .gt(gt_v[0])
  );

  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .eq(eq_v[1]), .lt(lt_v[1]), .gt(gt_v[1])
  );

  serial_mag_comparator #(.WIDTH(1), .EARLY_EXIT(1'b1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2][0:0]), .b(b_v[2][0:0]),
    .busy(busy_v[2]), .done(done_v[2]), .eq(eq_v[2]), .lt(lt_v[2]), .gt(gt_v[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain unsigned compare; latency from the highest differing bit.
  function automatic exp_t model(input int id, input logic [7:0] av, input logic [7:0] bv,
                                 input int e0);
    exp_t e;
    int   w, ua, ub, x;
    w  = (id == 2) ? 1 : 8;
    ua = int'(av) & ((1 << w) - 1);
    ub = int'(bv) & ((1 << w) - 1);
    x  = ua ^ ub;
    e.id  = id;
    e.e0  = e0;
    e.lat = (x == 0 || id == 1) ? w : w - ($clog2(x + 1) - 1);
    e.done_cyc = e0 + e.lat;
    e.eq = (ua == ub);
    e.lt = (ua < ub);
    e.gt = (ua > ub);
    return e;
  endfunction

  task automatic mon(input int id);
    int   hit;
    logic exp_busy, exp_done;
    hit      = -1;
    exp_busy = 1'b0;
    foreach (q[i]) begin
      if (q[i].id == id) begin
        if (cyc >= q[i].e0 && cyc < q[i].done_cyc) exp_busy = 1'b1;
        if (hit < 0) hit = i;
      end
    end
    check($sformatf("busy[%0d]", id), busy_v[id], exp_busy);
    if (busy_v[id])
      check($sformatf("res_while_busy[%0d]", id), {eq_v[id], lt_v[id], gt_v[id]}, 3'b000);
    exp_done = (hit >= 0) && (q[hit].done_cyc == cyc);
    check($sformatf("done[%0d]", id), done_v[id], exp_done);
    if (exp_done) begin
      check($sformatf("eq_lt_gt[%0d]", id), {eq_v[id], lt_v[id], gt_v[id]},
            {q[hit].eq, q[hit].lt, q[hit].gt});
      q.delete(hit);
    end else if (hit >= 0 && q[hit].done_cyc < cyc) begin
      q.delete(hit);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int id = 0; id < 3; id++) mon(id);
    end
  end

  // Called at a negedge with the target idle; start is sampled at the next edge.
  task automatic launch(input int id, input logic [7:0] av, input logic [7:0] bv,
                        output exp_t e);
    a_v[id]     = av;
    b_v[id]     = bv;
    start_v[id] = 1'b1;
    e = model(id, av, bv, cyc + 1);
    q.push_back(e);
  endtask

  task automatic single(input int id, input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    launch(id, av, bv, e);
    @(negedge clk);
    start_v[id] = 1'b0;
    repeat (e.lat + 1) @(negedge clk);
  endtask

  // start held high through the first compare; second operands applied while busy.
  task automatic b2b(input int id, input logic [7:0] a1, input logic [7:0] b1,
                     input logic [7:0] a2, input logic [7:0] b2);
    exp_t e1, e2;
    launch(id, a1, b1, e1);
    @(negedge clk);
    a_v[id] = a2;
    b_v[id] = b2;
    repeat (e1.lat) @(negedge clk);
    e2 = model(id, a2, b2, cyc + 1);
    q.push_back(e2);
    @(negedge clk);
    start_v[id] = 1'b0;
    repeat (e2.lat + 1) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t      e;
    logic [7:0] ra, rb;
    int         id;

    start_v = '0;
    for (int i = 0; i < 3; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy[%0d]", i), busy_v[i], 1'b0);
      check($sformatf("rst_done[%0d]", i), done_v[i], 1'b0);
      check($sformatf("rst_res[%0d]", i), {eq_v[i], lt_v[i], gt_v[i]}, 3'b000);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      single(i, 8'h5A, 8'h5A);
      single(i, 8'h80, 8'h7F);
      single(i, 8'h12, 8'h13);
      single(i, 8'h13, 8'h12);
      single(i, 8'h00, 8'hFF);
      single(i, 8'hFF, 8'hFF);
    end

    // Early-exit unit: start pulsed again while busy is ignored.
    launch(0, 8'h40, 8'h20, e);
    @(negedge clk);
    a_v[0] = 8'h00;
    b_v[0] = 8'hFF;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Full-scan unit: start re-asserted for edge E3 is ignored.
    launch(1, 8'h40, 8'h20, e);
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (2) @(negedge clk);
    a_v[1]     = 8'h00;
    b_v[1]     = 8'hFF;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (6) @(negedge clk);

    // Reset asserted just after E4 of a running compare.
    launch(0, 8'hF0, 8'hF1, e);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q = q.find(x) with (x.id != 0);
    #1;
    check("abort_busy", busy_v[0], 1'b0);
    check("abort_done", done_v[0], 1'b0);
    check("abort_res", {eq_v[0], lt_v[0], gt_v[0]}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    single(0, 8'h33, 8'h31);
    single(0, 8'h31, 8'h33);

    b2b(0, 8'hC0, 8'h40, 8'h12, 8'h13);
    b2b(0, 8'h77, 8'h77, 8'h01, 8'h00);
    b2b(1, 8'hC0, 8'h40, 8'h5A, 8'h5A);

    single(2, 8'h00, 8'h00);
    single(2, 8'h01, 8'h00);
    single(2, 8'h00, 8'h01);
    single(2, 8'h01, 8'h01);
    b2b(2, 8'h01, 8'h00, 8'h00, 8'h01);

    for (int n = 0; n < 90; n++) begin
      id = n % 3;
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) b2b(id, ra, rb, rb, ra);
      else                           single(id, ra, rb);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
